// File: rtl/kronos_id_decode.sv
// RV32I decode stage: register-file read, immediate generation and ALU operand select,
// with a pending-write scoreboard that stalls read-after-write hazards (no forwarding).
module kronos_id_decode #(
  parameter bit CATCH_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_ir,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic        flush,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  wb_rd,
  input  logic        wb_we,
  output logic [31:0] out_pc,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [31:0] out_imm,
  output logic [31:0] out_sdata,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic [3:0]  out_aluop,
  output logic        out_ld,
  output logic        out_st,
  output logic        out_br,
  output logic        out_jal,
  output logic        out_jalr,
  output logic        out_illegal,
  output logic        out_vld,
  input  logic        out_rdy
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode   = in_ir[6:0];
  assign funct3   = in_ir[14:12];
  assign funct7   = in_ir[31:25];
  assign rd       = in_ir[11:7];
  assign rs1_addr = in_ir[19:15];
  assign rs2_addr = in_ir[24:20];

  assign imm_i = {{20{in_ir[31]}}, in_ir[31:20]};
  assign imm_s = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
  assign imm_b = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
  assign imm_u = {in_ir[31:12], 12'b0};
  assign imm_j = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};

  logic [31:0] d_op1, d_op2, d_imm, d_sdata;
  logic [3:0]  d_aluop;
  logic        d_we, d_ld, d_st, d_br, d_jal, d_jalr, d_ill;
  logic        use_rs1, use_rs2, is_illegal;

  always_comb begin
    d_op1      = '0;
    d_op2      = '0;
    d_imm      = '0;
    d_sdata    = '0;
    d_aluop    = '0;
    d_we       = 1'b0;
    d_ld       = 1'b0;
    d_st       = 1'b0;
    d_br       = 1'b0;
    d_jal      = 1'b0;
    d_jalr     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    is_illegal = (in_ir[1:0] != 2'b11);
    case (opcode)
      OpLui: begin
        d_op2 = imm_u;
        d_we  = 1'b1;
      end
      OpAuipc: begin
        d_op1 = in_pc;
        d_op2 = imm_u;
        d_we  = 1'b1;
      end
      OpJal: begin
        d_op1 = in_pc;
        d_op2 = 32'd4;
        d_imm = imm_j;
        d_we  = 1'b1;
        d_jal = 1'b1;
      end
      OpJalr: begin
        d_op1   = in_pc;
        d_op2   = 32'd4;
        d_imm   = imm_i;
        d_we    = 1'b1;
        d_jalr  = 1'b1;
        use_rs1 = 1'b1;
      end
      OpBranch: begin
        d_op1   = rs1_data;
        d_op2   = rs2_data;
        d_imm   = imm_b;
        d_br    = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OpLoad: begin
        d_op1   = rs1_data;
        d_op2   = imm_i;
        d_imm   = imm_i;
        d_ld    = 1'b1;
        d_we    = 1'b1;
        use_rs1 = 1'b1;
      end
      OpStore: begin
        d_op1   = rs1_data;
        d_op2   = imm_s;
        d_imm   = imm_s;
        d_sdata = rs2_data;
        d_st    = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OpImm: begin
        d_op1   = rs1_data;
        d_op2   = imm_i;
        d_we    = 1'b1;
        use_rs1 = 1'b1;
        d_aluop = {(funct3 == 3'b101) && in_ir[30], funct3};
        // Shift-immediates reuse funct7 as an encoding field
        if (funct3 == 3'b001 && funct7 != 7'h00) is_illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20) is_illegal = 1'b1;
      end
      OpOp: begin
        d_op1   = rs1_data;
        d_op2   = rs2_data;
        d_we    = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        d_aluop = {in_ir[30], funct3};
        if (funct7 != 7'h00 && funct7 != 7'h20) is_illegal = 1'b1;
      end
      OpMisc, OpSystem: ;
      default: is_illegal = 1'b1;
    endcase
    if (is_illegal) begin
      d_op1   = '0;
      d_op2   = '0;
      d_imm   = '0;
      d_sdata = '0;
      d_aluop = '0;
      d_we    = 1'b0;
      d_ld    = 1'b0;
      d_st    = 1'b0;
      d_br    = 1'b0;
      d_jal   = 1'b0;
      d_jalr  = 1'b0;
    end
    if (rd == 5'd0) d_we = 1'b0;
    d_ill = is_illegal && CATCH_ILLEGAL;
  end

  // Hazard detection: a same-cycle writeback hides the scoreboard bit, and the packet
  // sitting in the output register counts as pending until it reaches the scoreboard.
  logic [31:0] sb_q, sb_d, pend;
  logic        haz, adv, accept;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      pend[i] = (sb_q[i] && !(wb_we && wb_rd == i[4:0])) ||
                (out_vld && out_we && out_rd == i[4:0]);
    end
  end

  assign haz = (use_rs1 && !is_illegal && rs1_addr != 5'd0 && pend[rs1_addr]) ||
               (use_rs2 && !is_illegal && rs2_addr != 5'd0 && pend[rs2_addr]);

  assign adv    = ~out_vld | out_rdy;
  assign in_rdy = adv & ~haz & ~flush;
  assign accept = in_vld & in_rdy;

  always_comb begin
    sb_d = sb_q;
    if (wb_we) sb_d[wb_rd] = 1'b0;
    if (out_vld && out_rdy && out_we && out_rd != 5'd0) sb_d[out_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      out_vld     <= 1'b0;
      out_pc      <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_sdata   <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_aluop   <= '0;
      out_ld      <= 1'b0;
      out_st      <= 1'b0;
      out_br      <= 1'b0;
      out_jal     <= 1'b0;
      out_jalr    <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (accept) begin
      out_vld     <= 1'b1;
      out_pc      <= in_pc;
      out_op1     <= d_op1;
      out_op2     <= d_op2;
      out_imm     <= d_imm;
      out_sdata   <= d_sdata;
      out_rd      <= rd;
      out_we      <= d_we;
      out_aluop   <= d_aluop;
      out_ld      <= d_ld;
      out_st      <= d_st;
      out_br      <= d_br;
      out_jal     <= d_jal;
      out_jalr    <= d_jalr;
      out_illegal <= d_ill;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule
